// File: rtl/axi4l_mem.sv
// axi4l_mem: AXI4-Lite subordinate backed by byte-addressable register storage
package axi_default_param_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi4l_aw_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axi4l_w_t;
  typedef struct packed {
    logic [1:0] resp;
  } axi4l_b_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi4l_ar_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axi4l_r_t;
  typedef struct packed {
    axi4l_aw_t aw;
    logic      aw_valid;
    axi4l_w_t  w;
    logic      w_valid;
    logic      b_ready;
    axi4l_ar_t ar;
    logic      ar_valid;
    logic      r_ready;
  } axi4l_req_t;
  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    axi4l_b_t b;
    logic     b_valid;
    logic     ar_ready;
    axi4l_r_t r;
    logic     r_valid;
  } axi4l_resp_t;
endpackage

module axi4l_mem #(
  parameter type axi_req_t = axi_default_param_pkg::axi4l_req_t,
  parameter type axi_resp_t = axi_default_param_pkg::axi4l_resp_t,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic      clk_i,
  input  logic      arst_ni,
  input  axi_req_t  req_i,
  output axi_resp_t resp_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WORDS = MEM_SIZE / STRB_W;
  localparam int OFF_W = $clog2(STRB_W);
  localparam int IDX_W = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int SIZE_W = $clog2(MEM_SIZE);
  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
  wr_state_e wr_q, wr_d;
  rd_state_e rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0] w_data_q, wr_data, r_data_q;
  logic [STRB_W-1:0] w_strb_q, wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [1:0] b_resp_q, r_resp_q;
  logic aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs, commit, wr_in, rd_in;
  logic unused_prot;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  assign aw_rdy = wr_q == WR_IDLE || wr_q == WR_HAVE_W;
  assign w_rdy = wr_q == WR_IDLE || wr_q == WR_HAVE_AW;
  assign ar_rdy = rd_q == RD_IDLE;
  assign aw_hs = req_i.aw_valid && aw_rdy;
  assign w_hs = req_i.w_valid && w_rdy;
  assign ar_hs = req_i.ar_valid && ar_rdy;
  assign unused_prot = ^{req_i.aw.prot, req_i.ar.prot};
  // the half that arrived first comes from the capture registers, the other straight from the bus
  assign wr_addr = wr_q == WR_HAVE_AW ? aw_addr_q : req_i.aw.addr;
  assign wr_data = wr_q == WR_HAVE_W ? w_data_q : req_i.w.data;
  assign wr_strb = wr_q == WR_HAVE_W ? w_strb_q : req_i.w.strb;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = req_i.ar.addr - BASE_ADDR;
  assign wr_in = (wr_off >> SIZE_W) == '0;
  assign rd_in = (rd_off >> SIZE_W) == '0;
  assign wr_idx = wr_off[OFF_W +: IDX_W];
  assign rd_idx = rd_off[OFF_W +: IDX_W];
  assign commit = arst_ni && wr_q != WR_RESP && wr_d == WR_RESP;
  always_comb begin
    wr_d = wr_q;
    case (wr_q)
      WR_IDLE:    wr_d = aw_hs && w_hs ? WR_RESP : aw_hs ? WR_HAVE_AW : w_hs ? WR_HAVE_W : WR_IDLE;
      WR_HAVE_AW: wr_d = w_hs ? WR_RESP : WR_HAVE_AW;
      WR_HAVE_W:  wr_d = aw_hs ? WR_RESP : WR_HAVE_W;
      default:    wr_d = req_i.b_ready ? WR_IDLE : WR_RESP;
    endcase
  end
  always_comb begin
    rd_d = rd_q == RD_IDLE ? (ar_hs ? RD_RESP : RD_IDLE) : (req_i.r_ready ? RD_IDLE : RD_RESP);
  end
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
      aw_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      b_resp_q <= 2'b00;
      r_resp_q <= 2'b00;
      r_data_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (aw_hs) aw_addr_q <= req_i.aw.addr;
      if (w_hs) begin
        w_data_q <= req_i.w.data;
        w_strb_q <= req_i.w.strb;
      end
      if (commit) b_resp_q <= wr_in ? 2'b00 : 2'b10;
      if (ar_hs) begin
        r_data_q <= rd_in ? mem[rd_idx] : '0;
        r_resp_q <= rd_in ? 2'b00 : 2'b10;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (commit && wr_in)
      for (int i = 0; i < STRB_W; i++)
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
  end
  always_comb begin
    resp_o = '0;
    resp_o.aw_ready = aw_rdy;
    resp_o.w_ready = w_rdy;
    resp_o.b_valid = wr_q == WR_RESP;
    resp_o.b.resp = b_resp_q;
    resp_o.ar_ready = ar_rdy;
    resp_o.r_valid = rd_q == RD_RESP;
    resp_o.r.data = r_data_q;
    resp_o.r.resp = r_resp_q;
  end
endmodule

// File: tb/tb_axi4l_mem.sv
// tb_axi4l_mem: directed table, corner-case sequences and random traffic against a word-array model
module tb_axi4l_mem;
  import axi_default_param_pkg::*;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] MEM = 32'd1024;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          hold;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  logic clk = 1'b0;
  logic arst_n;
  axi4l_req_t req;
  axi4l_resp_t rsp;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [256];
  vec_t vt[$];

  axi4l_mem #(.BASE_ADDR(BASE)) dut (.clk_i(clk), .arst_ni(arst_n), .req_i(req), .resp_o(rsp));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < MEM;
  endfunction

  function automatic void mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] o;
    o = a - BASE;
    if (o < MEM)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[o[9:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < MEM ? model[o[9:2]] : 32'h0;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, output logic [1:0] bresp);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    aw_done = 0;
    w_done = 0;
    cyc = 0;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (cyc > 0) chk("b_early", rsp.b_valid, 0);
      if (cyc > 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_timeout: got no AW/W handshake within 40 cycles, required both");
        break;
      end
      req.aw_valid = !aw_done && cyc >= aw_dly;
      req.aw.addr = addr;
      req.w_valid = !w_done && cyc >= w_dly;
      req.w.data = data;
      req.w.strb = strb;
      hs_aw = req.aw_valid && rsp.aw_ready;
      hs_w = req.w_valid && rsp.w_ready;
      @(posedge clk);
      aw_done |= hs_aw;
      w_done |= hs_w;
      cyc++;
    end
    @(negedge clk);
    req.aw_valid = 0;
    req.w_valid = 0;
    chk("b_valid", rsp.b_valid, 1);
    bresp = rsp.b.resp;
    @(posedge clk);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, output logic [31:0] d, output logic [1:0] r);
    int cyc;
    cyc = 0;
    @(negedge clk);
    req.ar_valid = 1;
    req.ar.addr = addr;
    while (!rsp.ar_ready && cyc <= 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc > 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL rd_timeout: got ar_ready=0 for 40 cycles, required 1");
    end
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 0;
    chk("r_valid", rsp.r_valid, 1);
    d = rsp.r.data;
    r = rsp.r.resp;
    if (hold > 0) begin
      req.r_ready = 0;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        chk("r_hold_valid", rsp.r_valid, 1);
        chk("r_hold_data", rsp.r.data, d);
        chk("r_hold_resp", rsp.r.resp, r);
        chk("r_hold_arready", rsp.ar_ready, 0);
      end
      req.r_ready = 1;
    end
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] br, rr;
    logic [31:0] rd;
    vt.push_back('{1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 2'b00});
    vt.push_back('{0, BASE + 32'h10, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00});
    vt.push_back('{1, BASE + 32'h20, 32'h11223344, 4'hF, 3, 0, 0, 32'h0, 2'b00});
    vt.push_back('{1, BASE + 32'h20, 32'h0000AA00, 4'h2, 0, 0, 0, 32'h0, 2'b00});
    vt.push_back('{0, BASE + 32'h20, 32'h0, 4'h0, 0, 0, 0, 32'h1122AA44, 2'b00});
    vt.push_back('{1, BASE + 32'h0, 32'h77777777, 4'hF, 1, 1, 0, 32'h0, 2'b00});
    vt.push_back('{1, BASE + MEM, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 32'h0, 2'b10});
    vt.push_back('{0, BASE + MEM, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b10});
    vt.push_back('{0, BASE + 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h77777777, 2'b00});
    vt.push_back('{0, BASE + 32'h3FC, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00});
    vt.push_back('{1, BASE - 32'h4, 32'hCAFEF00D, 4'hF, 0, 0, 0, 32'h0, 2'b10});
    vt.push_back('{0, BASE - 32'h4, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b10});
    vt.push_back('{0, BASE + 32'h3FC, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00});
    vt.push_back('{0, BASE + 32'h13, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00});
    vt.push_back('{1, BASE + 32'h24, 32'h12345678, 4'h9, 0, 2, 0, 32'h0, 2'b00});
    vt.push_back('{0, BASE + 32'h24, 32'h0, 4'h0, 0, 0, 1, 32'h12000078, 2'b00});
    vt.push_back('{1, BASE + 32'h3FD, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 32'h0, 2'b00});
    vt.push_back('{0, BASE + 32'h3FC, 32'h0, 4'h0, 0, 0, 0, 32'hA5A5A5A5, 2'b00});
    vt.push_back('{0, BASE + 32'h14, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b00});
    req = '0;
    req.b_ready = 1;
    req.r_ready = 1;
    arst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_b_valid", rsp.b_valid, 0);
    chk("rst_r_valid", rsp.r_valid, 0);
    chk("rst_b_resp", rsp.b.resp, 0);
    chk("rst_r_resp", rsp.r.resp, 0);
    chk("rst_r_data", rsp.r.data, 0);
    arst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_aw_ready", rsp.aw_ready, 1);
    chk("rel_w_ready", rsp.w_ready, 1);
    chk("rel_ar_ready", rsp.ar_ready, 1);
    for (int i = 0; i < 256; i++) begin
      do_write(BASE + 32'(4 * i), 32'h0, 4'hF, 0, 0, br);
      chk("init_bresp", br, 2'b00);
      model[i] = 32'h0;
    end
    foreach (vt[k]) begin
      if (vt[k].wr) begin
        do_write(vt[k].addr, vt[k].data, vt[k].strb, vt[k].aw_dly, vt[k].w_dly, br);
        chk($sformatf("vec%0d_bresp", k), br, vt[k].exp_resp);
        mdl_wr(vt[k].addr, vt[k].data, vt[k].strb);
      end else begin
        do_read(vt[k].addr, vt[k].hold, rd, rr);
        chk($sformatf("vec%0d_rdata", k), rd, vt[k].exp_data);
        chk($sformatf("vec%0d_rresp", k), rr, vt[k].exp_resp);
      end
    end
    do_read(BASE + 32'h20, 5, rd, rr);
    chk("stall_rdata", rd, 32'h1122AA44);
    chk("stall_rresp", rr, 2'b00);
    @(negedge clk);
    req.ar_valid = 1;
    req.ar.addr = BASE + 32'h10;
    chk("ar_after_r", rsp.ar_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 0;
    chk("b2b_r_valid", rsp.r_valid, 1);
    chk("b2b_r_data", rsp.r.data, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    req.aw_valid = 1;
    req.aw.addr = BASE + 32'h40;
    req.w_valid = 1;
    req.w.data = 32'h5;
    req.w.strb = 4'hF;
    req.ar_valid = 1;
    req.ar.addr = BASE + 32'h40;
    @(posedge clk);
    @(negedge clk);
    req.aw_valid = 0;
    req.w_valid = 0;
    req.ar_valid = 0;
    chk("rw_b_valid", rsp.b_valid, 1);
    chk("rw_r_valid", rsp.r_valid, 1);
    chk("rw_old_data", rsp.r.data, 32'h0);
    mdl_wr(BASE + 32'h40, 32'h5, 4'hF);
    @(posedge clk);
    do_read(BASE + 32'h40, 0, rd, rr);
    chk("rw_new_data", rd, 32'h5);
    @(negedge clk);
    req.aw_valid = 1;
    req.aw.addr = BASE + 32'h10;
    req.ar_valid = 1;
    req.ar.addr = BASE + 32'h10;
    req.r_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req.aw_valid = 0;
    req.ar_valid = 0;
    chk("pre_rst_r_valid", rsp.r_valid, 1);
    chk("pre_rst_aw_ready", rsp.aw_ready, 0);
    arst_n = 0;
    @(posedge clk);
    @(negedge clk);
    arst_n = 1;
    chk("mid_rst_b_valid", rsp.b_valid, 0);
    chk("mid_rst_r_valid", rsp.r_valid, 0);
    chk("mid_rst_r_data", rsp.r.data, 0);
    chk("mid_rst_aw_ready", rsp.aw_ready, 1);
    chk("mid_rst_w_ready", rsp.w_ready, 1);
    chk("mid_rst_ar_ready", rsp.ar_ready, 1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_no_b", rsp.b_valid, 0);
      chk("post_rst_no_r", rsp.r_valid, 0);
    end
    req.r_ready = 1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d;
      logic [3:0] s;
      a = BASE + $urandom_range(0, 1100);
      if ($urandom_range(0, 15) == 0) a = BASE - $urandom_range(1, 64);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), br);
        chk("rnd_bresp", br, in_rng(a) ? 2'b00 : 2'b10);
        mdl_wr(a, d, s);
      end else begin
        do_read(a, $urandom_range(0, 2), rd, rr);
        chk("rnd_rdata", rd, mdl_rd(a));
        chk("rnd_rresp", rr, in_rng(a) ? 2'b00 : 2'b10);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
